tracker_arbiter: RTL
====================

TRACKER_ARBITER -- requirements
Module: tracker_arbiter

Interface
REQ-001 Parameter N_CH, 4: number of tracked-signal channels, 2..8.
REQ-002 Parameter TS_W, 32: timestamp and duration width.
REQ-003 Reset rst, asynchronous, active-high; clock clk.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 sig_in  input  N_CH  tracked signals, one per channel, synchronous to clk.
REQ-007 range_lo  input  TS_W  inclusive lower duration bound (macro-dependent, see Configuration).
REQ-008 range_hi  input  TS_W  inclusive upper duration bound (macro-dependent).
REQ-009 out_ready  input  1  consumer accepts the current record.
REQ-010 out_valid  output  1  record on out_* is valid.
REQ-011 out_ch  output  $clog2(N_CH)  channel index of the record.
REQ-012 out_start  output  TS_W  timestamp of the rising edge.
REQ-013 out_end  output  TS_W  timestamp of the falling edge.
REQ-014 out_in_range  output  1  duration lies within [range_lo, range_hi].
REQ-015 timestamp  output  TS_W  free-running cycle counter.
REQ-016 overflow  output  N_CH  sticky per-channel dropped-record flag.

Function
REQ-017 timestamp SHALL read 0 in the first cycle after reset release, increment by 1 per clk, and wrap from 2^TS_W-1 to 0.
REQ-018 Each channel SHALL register sig_in; rising edge = sampled 1 with previous sample 0; falling edge = sampled 0 with previous sample 1.
REQ-019 On a rising edge the channel SHALL capture start = timestamp and enter state HIGH; from IDLE only.
REQ-020 On a falling edge in HIGH the channel SHALL capture end = timestamp, compute duration = end - start modulo 2^TS_W, and return to IDLE.
REQ-021 A completed interval SHALL be written to the channel's one-deep pending slot at the edge following the falling-edge sample.
REQ-022 If the pending slot is still occupied and not granted that cycle, the new record SHALL be dropped, the old record kept, and overflow[ch] set until reset.
REQ-023 If the occupying record is granted in the same cycle a new record arrives, the new record SHALL be stored with no overflow.
REQ-024 The arbiter SHALL grant pending slots round-robin, searching from (last granted + 1) mod N_CH; the pointer after reset is channel 0.
REQ-025 A grant SHALL load the output register when out_valid is 0 or out_valid and out_ready are both 1 (back-to-back transfer, no bubble).
REQ-026 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 Minimum latency: falling edge sampled at cycle T -> pending at T+1 -> out_valid at T+2.
REQ-028 A one-cycle sig_in pulse SHALL produce duration 1; a pulse spanning timestamp wrap SHALL produce the modular duration.

Reset
REQ-029 On rst: timestamp=0, all channels IDLE, previous samples=0, pending slots empty, overflow=0, out_valid=0, out_ch/out_start/out_end/out_in_range=0, RR pointer=0.
REQ-030 Reset mid-interval or mid-handshake SHALL discard all in-flight records; a sig_in high at reset release SHALL count as a rising edge.

Configuration
REQ-031 Macro TRACKER_ARB_RANGE_CHECK_EN defined: range_lo/range_hi ports present, out_in_range = (range_lo <= duration <= range_hi), sampled when the record is written to the pending slot.
REQ-032 Macro TRACKER_ARB_RANGE_CHECK_EN undefined: range_lo/range_hi ports absent, out_in_range tied to 1.

Verification
REQ-033 Single pulse: ch0 high at timestamp 5, low at 9, out_ready=1 -> one record ch=0, start=5, end=9, out_valid 2 cycles after falling edge.
REQ-034 Range: range_lo=1, range_hi=3; durations 1, 3, 4 on ch1 -> out_in_range 1, 1, 0 (macro on); all 1 (macro off).
REQ-035 Fairness: all 4 channels complete in the same cycle, out_ready=1 -> records in order ch0,ch1,ch2,ch3 on consecutive cycles; next simultaneous batch after ch3 starts at ch0.
REQ-036 Backpressure/overflow: out_ready=0, ch2 completes twice -> first record held stable, overflow[2]=1, second record dropped.
REQ-037 Wrap: TS_W=4, pulse from timestamp 14 to 2 -> start=14, end=2, duration 4.
REQ-038 Reset mid-operation: assert rst while out_valid=1 and ch0 HIGH -> all outputs 0 next cycle, no stale record after release.

Source files
------------

// File: rtl/tracker_arbiter.sv
// tracker_arbiter
//   Measures high intervals on N_CH tracked signals against a free-running
//   timestamp. Each completed interval becomes a record {channel, start, end,
//   in_range} held in a one-deep per-channel pending slot. A round-robin
//   arbiter moves pending records into a single valid/ready output register.
//
// Optional feature macro: TRACKER_ARB_RANGE_CHECK_EN
//   defined   : range_lo/range_hi ports exist; out_in_range reports whether
//               (end - start) mod 2^TS_W lies in [range_lo, range_hi], using
//               the bounds present when the record enters its pending slot.
//   undefined : no range ports; every record carries out_in_range = 1.
//
// Ports:
//   clk           rising-edge clock for all state
//   rst           asynchronous active-high reset
//   sig_in        [N_CH]   tracked signals, synchronous to clk
//   range_lo/hi   [TS_W]   inclusive duration bounds (macro only)
//   out_ready     consumer accepts the current record
//   out_valid     record on out_* is valid
//   out_ch        [$clog2(N_CH)] channel of the record
//   out_start     [TS_W]   timestamp of the rising edge
//   out_end       [TS_W]   timestamp of the falling edge
//   out_in_range  duration within bounds
//   timestamp     [TS_W]   free-running cycle counter
//   overflow      [N_CH]   sticky per-channel dropped-record flag
module tracker_arbiter #(
  parameter int N_CH = 4,
  parameter int TS_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           sig_in,
`ifdef TRACKER_ARB_RANGE_CHECK_EN
  input  logic [TS_W-1:0]           range_lo,
  input  logic [TS_W-1:0]           range_hi,
`endif
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [$clog2(N_CH)-1:0]   out_ch,
  output logic [TS_W-1:0]           out_start,
  output logic [TS_W-1:0]           out_end,
  output logic                      out_in_range,
  output logic [TS_W-1:0]           timestamp,
  output logic [N_CH-1:0]           overflow
);

  localparam int CH_W = $clog2(N_CH);
  localparam logic [CH_W:0]   N_CH_X  = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic {IDLE, HIGH} ch_state_t;

  logic [TS_W-1:0] ts_reg;

  // Per-channel pending slots, gathered for the arbiter and output mux.
  logic [N_CH-1:0] pend_valid;
  logic [TS_W-1:0] pend_start [N_CH];
  logic [TS_W-1:0] pend_end   [N_CH];
  logic [N_CH-1:0] pend_in_range;
  logic [N_CH-1:0] gnt_vec;

  logic [CH_W-1:0] rr_reg;
  logic [CH_W-1:0] gnt_idx;
  logic [CH_W:0]   cand;
  logic            gnt_any;
  logic            gnt_fire;

  logic            out_valid_reg;
  logic [CH_W-1:0] out_ch_reg;
  logic [TS_W-1:0] out_start_reg;
  logic [TS_W-1:0] out_end_reg;
  logic            out_in_range_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_reg <= '0;
    else     ts_reg <= ts_reg + TS_W'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      ch_state_t       state_reg, state_next;
      logic            sample_reg, prev_reg;
      logic [TS_W-1:0] start_reg, start_next;
      logic            done;
      logic            rec_in_range;
      logic            slot_valid_reg;
      logic [TS_W-1:0] slot_start_reg, slot_end_reg;
      logic            slot_in_range_reg;
      logic            ovf_reg;

`ifdef TRACKER_ARB_RANGE_CHECK_EN
      logic [TS_W-1:0] duration;
      // Modular subtraction gives the right length for intervals that
      // straddle a timestamp wrap.
      assign duration     = ts_reg - start_reg;
      assign rec_in_range = (duration >= range_lo) && (duration <= range_hi);
`else
      assign rec_in_range = 1'b1;
`endif

      // Interval FSM works on the registered sample and the sample before it.
      always_comb begin
        state_next = state_reg;
        start_next = start_reg;
        done       = 1'b0;
        case (state_reg)
          IDLE: if (sample_reg && !prev_reg) begin
            state_next = HIGH;
            start_next = ts_reg;
          end
          HIGH: if (!sample_reg && prev_reg) begin
            state_next = IDLE;
            done       = 1'b1;
          end
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg         <= IDLE;
          start_reg         <= '0;
          sample_reg        <= 1'b0;
          prev_reg          <= 1'b0;
          slot_valid_reg    <= 1'b0;
          slot_start_reg    <= '0;
          slot_end_reg      <= '0;
          slot_in_range_reg <= 1'b0;
          ovf_reg           <= 1'b0;
        end else begin
          state_reg  <= state_next;
          start_reg  <= start_next;
          sample_reg <= sig_in[gi];
          prev_reg   <= sample_reg;
          if (gnt_vec[gi]) slot_valid_reg <= 1'b0;
          // A slot being granted this cycle is free for the new record.
          if (done) begin
            if (slot_valid_reg && !gnt_vec[gi]) begin
              ovf_reg <= 1'b1;
            end else begin
              slot_valid_reg    <= 1'b1;
              slot_start_reg    <= start_reg;
              slot_end_reg      <= ts_reg;
              slot_in_range_reg <= rec_in_range;
            end
          end
        end
      end

      assign pend_valid[gi]    = slot_valid_reg;
      assign pend_start[gi]    = slot_start_reg;
      assign pend_end[gi]      = slot_end_reg;
      assign pend_in_range[gi] = slot_in_range_reg;
      assign overflow[gi]      = ovf_reg;
    end
  endgenerate

  // Round-robin search starting at rr_reg. Scanning offsets from the far end
  // down lets the nearest pending channel overwrite any farther one.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = {1'b0, rr_reg} + (CH_W+1)'(k);
      if (cand >= N_CH_X) cand = cand - N_CH_X;
      if (pend_valid[cand[CH_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[CH_W-1:0];
      end
    end
  end

  // Output register may reload when empty or when being drained this cycle.
  assign gnt_fire = gnt_any && (!out_valid_reg || out_ready);

  always_comb begin
    gnt_vec = '0;
    if (gnt_fire) gnt_vec[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg    <= 1'b0;
      out_ch_reg       <= '0;
      out_start_reg    <= '0;
      out_end_reg      <= '0;
      out_in_range_reg <= 1'b0;
      rr_reg           <= '0;
    end else if (gnt_fire) begin
      out_valid_reg    <= 1'b1;
      out_ch_reg       <= gnt_idx;
      out_start_reg    <= pend_start[gnt_idx];
      out_end_reg      <= pend_end[gnt_idx];
      out_in_range_reg <= pend_in_range[gnt_idx];
      rr_reg           <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_W'(1);
    end else if (out_ready) begin
      out_valid_reg    <= 1'b0;
    end
  end

  assign timestamp    = ts_reg;
  assign out_valid    = out_valid_reg;
  assign out_ch       = out_ch_reg;
  assign out_start    = out_start_reg;
  assign out_end      = out_end_reg;
  assign out_in_range = out_in_range_reg;

endmodule
